// File: rtl/bias_mem_rmw_pkg.sv
// Shared types and saturation helpers for the bias memory and the weight-update blocks.
// The helpers are generic over word widths up to 63 bits.
package bias_mem_rmw_pkg;

  typedef struct packed {
    int width;
    int depth;
  } bias_mem_cfg;

  function automatic logic signed [63:0] SAT_MAX(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] SAT_MIN(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Operands must already be sign-extended to 64 bits.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int                 w);
    logic signed [63:0] s;
    s = a + b;
    if (s > SAT_MAX(w)) return SAT_MAX(w);
    if (s < SAT_MIN(w)) return SAT_MIN(w);
    return s;
  endfunction

endpackage

// File: rtl/bias_sat_add.sv
// Combinational signed add in WIDTH+1 bits, clamped back to the WIDTH-bit range.
module bias_sat_add
  import bias_mem_rmw_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y
);

  localparam logic signed [WIDTH-1:0] MAX_V = WIDTH'(SAT_MAX(WIDTH));
  localparam logic signed [WIDTH-1:0] MIN_V = WIDTH'(SAT_MIN(WIDTH));

  // Overflow shows up as the two top bits of the extended sum disagreeing.
  function automatic logic signed [WIDTH-1:0] clamp(input logic signed [WIDTH:0] s);
    if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? MIN_V : MAX_V;
    return s[WIDTH-1:0];
  endfunction

  logic signed [WIDTH:0] sum;

  assign sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign y   = clamp(sum);

endmodule

// File: rtl/bias_mem_rmw.sv
// Bias storage with auto-incrementing load stream and registered read port.
// Define BIAS_MEM_RMW_EN to build the saturating read-modify-write update path.
module bias_mem_rmw
  import bias_mem_rmw_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  input  logic                    load_first,
  input  logic signed [WIDTH-1:0] load_data,
  output logic                    load_ready,
  output logic                    load_done,
  input  logic                    rd_en,
  input  logic [AW-1:0]           rd_addr,
  output logic signed [WIDTH-1:0] rd_data,
  output logic                    rd_valid,
  input  logic                    upd_valid,
  input  logic [AW-1:0]           upd_addr,
  input  logic signed [WIDTH-1:0] upd_delta,
  output logic                    upd_ready,
  output logic                    busy
);

  localparam bias_mem_cfg CFG = '{width: WIDTH, depth: DEPTH};

  function automatic logic in_range(input logic [AW-1:0] a);
    return int'(a) < CFG.depth;
  endfunction

  logic signed [CFG.width-1:0] mem [DEPTH];

  logic [AW-1:0]           ptr;
  logic [AW-1:0]           ld_addr;
  logic [AW-1:0]           ptr_next;
  logic                    load_acc;

  logic                    upd_wr;
  logic [AW-1:0]           upd_wr_addr;
  logic signed [WIDTH-1:0] upd_wr_data;

  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic signed [WIDTH-1:0] wr_data;

`ifdef BIAS_MEM_RMW_EN
  logic                    vld_p2;
  logic [AW-1:0]           addr_p2;
  logic signed [WIDTH-1:0] res_p2;
  logic signed [WIDTH-1:0] opnd_p1;
  logic signed [WIDTH-1:0] sum_p1;

  // Stage 1: operand fetch with forwarding from the stage-2 write, then saturating add.
  assign opnd_p1 = (vld_p2 && (addr_p2 == upd_addr)) ? res_p2 : mem[upd_addr];

  bias_sat_add #(.WIDTH(WIDTH)) u_sat_add (
    .a (opnd_p1),
    .b (upd_delta),
    .y (sum_p1)
  );

  // Out-of-range requests are accepted but never reach stage 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p2 <= 1'b0;
    else       vld_p2 <= upd_valid && in_range(upd_addr);
  end

  // Stage 2: result register feeding the shared write port.
  always_ff @(posedge clk) begin
    if (upd_valid) begin
      addr_p2 <= upd_addr;
      res_p2  <= sum_p1;
    end
  end

  assign upd_wr      = vld_p2;
  assign upd_wr_addr = addr_p2;
  assign upd_wr_data = res_p2;
  assign upd_ready   = 1'b1;
`else
  logic unused_upd;

  assign unused_upd  = ^{upd_valid, upd_addr, upd_delta};
  assign upd_wr      = 1'b0;
  assign upd_wr_addr = '0;
  assign upd_wr_data = '0;
  assign upd_ready   = 1'b0;
`endif

  assign busy       = upd_wr;
  assign load_ready = !upd_wr;
  assign load_acc   = load_valid && load_ready;
  assign ld_addr    = load_first ? '0 : ptr;
  assign ptr_next   = (int'(ld_addr) == DEPTH - 1) ? '0 : ld_addr + AW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= load_acc && (int'(ld_addr) == DEPTH - 1);
      if (load_acc) ptr <= ptr_next;
    end
  end

  // Single write port; the update write wins and holds the load off.
  always_comb begin
    wr_en   = load_acc;
    wr_addr = ld_addr;
    wr_data = load_data;
    if (upd_wr) begin
      wr_en   = 1'b1;
      wr_addr = upd_wr_addr;
      wr_data = upd_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read stage: registered, read-before-write against the array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= in_range(rd_addr) ? mem[rd_addr] : '0;
    end
  end

endmodule
